trk_code_car_nco: RTL and testbench
===================================

Name: trk_code_car_nco

Overview:
- Numerically controlled oscillator pair that consumes the tracking-loop frequency control words `tx_prn_fcw` and `tx_car_fcw`.
- Generates carrier phase, code chip timing and the PRN epoch pulse `rx_prn_sop` that paces the loop filter and correlators; it sits between the tracking loop filter and the correlator/code generator.
- New FCWs are applied only at epoch boundaries, so each integration period runs at a constant rate.

Parameters:
- CODE_LEN, 2046, chips per PRN epoch (B1 code); legal range 2..2047.
- INIT_PRN_FCW, 32'h0, active code FCW after reset.
- INIT_CAR_FCW, 32'h0, active carrier FCW after reset.

Ports:
- rx_clk  in  1  system clock; single clock domain.
- rx_rst_n  in  1  synchronous, active-low reset.
- trk_en  in  1  NCO run enable; low freezes all state.
- tx_prn_fcw  in  32  code NCO FCW from the loop filter (unsigned, chips per clock × 2^32).
- tx_car_fcw  in  32  carrier NCO FCW from the loop filter (mod 2^32).
- fcw_load  in  1  one-cycle strobe: immediate FCW/phase load (acquisition handover).
- chip_init  in  11  code chip index loaded on fcw_load.
- car_phase  out  32  carrier phase accumulator.
- code_phase  out  32  fractional code phase accumulator.
- code_chip  out  11  current chip index, 0..CODE_LEN-1.
- chip_strobe  out  1  1-cycle pulse when a chip boundary is crossed.
- half_chip_strobe  out  1  1-cycle pulse at mid-chip.
- rx_prn_sop  out  1  1-cycle pulse at PRN epoch start (chip wrap to 0).
- epoch_cnt  out  16  epochs since load; wraps modulo 2^16.
- prn_fcw_act  out  32  code FCW currently in use.
- car_fcw_act  out  32  carrier FCW currently in use.

Behaviour:
- Priority: reset > fcw_load > trk_en operation > hold.
- Reset (rx_rst_n=0 at an edge):
  - All accumulators, code_chip, epoch_cnt and strobes go to 0.
  - prn_fcw_act=INIT_PRN_FCW; car_fcw_act=INIT_CAR_FCW.
  - Reset mid-epoch discards all phase.
- fcw_load:
  - prn/car_fcw_act <= inputs; car_phase, code_phase <= 0; epoch_cnt <= 0; all strobes 0 that cycle.
  - code_chip <= chip_init if chip_init < CODE_LEN, else 0.
  - fcw_load is honoured regardless of trk_en.
- trk_en=1, each edge:
  - car_phase <= car_phase + car_fcw_act (mod 2^32).
  - {carry, code_phase} <= code_phase + prn_fcw_act (33-bit sum); at most one chip advance per clock.
  - carry=1: chip_strobe <= 1.
    - If code_chip == CODE_LEN-1: code_chip <= 0, rx_prn_sop <= 1, epoch_cnt <= epoch_cnt+1, and prn/car_fcw_act <= tx_prn_fcw/tx_car_fcw sampled that same edge.
    - Otherwise code_chip <= code_chip+1.
  - half_chip_strobe <= 1 when code_phase[31] goes 0→1 without carry.
- Strobe timing: all outputs are registered, and each strobe is high in the same cycle the new code_chip/phase value is visible. Strobes are 1 cycle wide.
- FCW changes on tx_* between epochs are ignored until the next rx_prn_sop edge. The loop filter's ~3-cycle update latency therefore lands on the following epoch.
- trk_en=0: all registers hold; strobes 0. No phase is lost across pause and resume.
- prn_fcw_act=0: no chips advance, so no sop is produced. prn_fcw_act=2^32-1 gives one chip per cycle less one every 2^32 clocks.
- fcw_load coinciding with a chip wrap: the load wins and no sop is emitted.

Test Plan:
- Reset: hold rx_rst_n=0 for 3 clocks with fcw inputs nonzero → all outputs 0, fcw_act = INIT values; release → state holds while trk_en=0.
- Epoch timing (CODE_LEN=4, INIT_PRN_FCW=32'h40000000, trk_en=1):
  - chip_strobe on clocks 4, 8, 12, 16.
  - half_chip_strobe on clocks 2, 6, 10, 14.
  - rx_prn_sop only on clock 16, with code_chip=0 and epoch_cnt=1.
- Epoch-aligned FCW update: same setup, tx_prn_fcw=32'h80000000 driven at clock 5 → chip period stays 4 until sop at clock 16; after it, chip_strobe every 2 clocks; prn_fcw_act changes exactly at clock 16.
- Load: fcw_load with chip_init=3, tx_prn_fcw=32'h40000000 → rx_prn_sop 4 clocks later. chip_init=2047 → code_chip=0.
- Carrier wrap: tx_car_fcw=32'h80000000 loaded → car_phase alternates 32'h80000000, 0 each clock.
- Pause: deassert trk_en for 10 clocks mid-chip → car_phase, code_phase and code_chip frozen, no strobes; resume continues from the held values.

Source files
------------

// File: rtl/trk_code_car_nco.sv
// trk_code_car_nco: carrier and code NCO pair producing chip/half-chip strobes and PRN epoch pulses.
// Loop-filter FCWs take effect only at epoch wrap so each integration runs at a constant rate.
module trk_code_car_nco #(
  parameter int          CODE_LEN     = 2046,
  parameter logic [31:0] INIT_PRN_FCW = 32'h0,
  parameter logic [31:0] INIT_CAR_FCW = 32'h0
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic        trk_en,
  input  logic [31:0] tx_prn_fcw,
  input  logic [31:0] tx_car_fcw,
  input  logic        fcw_load,
  input  logic [10:0] chip_init,
  output logic [31:0] car_phase,
  output logic [31:0] code_phase,
  output logic [10:0] code_chip,
  output logic        chip_strobe,
  output logic        half_chip_strobe,
  output logic        rx_prn_sop,
  output logic [15:0] epoch_cnt,
  output logic [31:0] prn_fcw_act,
  output logic [31:0] car_fcw_act
);
  localparam logic [10:0] LAST = 11'(CODE_LEN - 1);
  logic [32:0] code_sum;
  logic        carry;
  logic        wrap;
  logic        half;
  always_comb begin
    code_sum = {1'b0, code_phase} + {1'b0, prn_fcw_act};
    carry    = code_sum[32];
    wrap     = carry && code_chip == LAST;
    half     = !carry && !code_phase[31] && code_sum[31];
  end
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      car_phase        <= '0;
      code_phase       <= '0;
      code_chip        <= '0;
      chip_strobe      <= 1'b0;
      half_chip_strobe <= 1'b0;
      rx_prn_sop       <= 1'b0;
      epoch_cnt        <= '0;
      prn_fcw_act      <= INIT_PRN_FCW;
      car_fcw_act      <= INIT_CAR_FCW;
    end else if (fcw_load) begin
      car_phase        <= '0;
      code_phase       <= '0;
      code_chip        <= chip_init <= LAST ? chip_init : '0;
      chip_strobe      <= 1'b0;
      half_chip_strobe <= 1'b0;
      rx_prn_sop       <= 1'b0;
      epoch_cnt        <= '0;
      prn_fcw_act      <= tx_prn_fcw;
      car_fcw_act      <= tx_car_fcw;
    end else if (trk_en) begin
      car_phase        <= car_phase + car_fcw_act;
      code_phase       <= code_sum[31:0];
      code_chip        <= carry ? (wrap ? '0 : code_chip + 11'd1) : code_chip;
      chip_strobe      <= carry;
      half_chip_strobe <= half;
      rx_prn_sop       <= wrap;
      // new loop-filter words are latched only on the epoch wrap
      if (wrap) begin
        epoch_cnt   <= epoch_cnt + 16'd1;
        prn_fcw_act <= tx_prn_fcw;
        car_fcw_act <= tx_car_fcw;
      end
    end else begin
      chip_strobe      <= 1'b0;
      half_chip_strobe <= 1'b0;
      rx_prn_sop       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_trk_code_car_nco.sv
// tb_trk_code_car_nco: directed and randomized checks of the NCO pair against a total-phase reference model.
module tb_trk_code_car_nco;
  localparam int          CL   = 4;
  localparam logic [31:0] IPRN = 32'h40000000;
  localparam logic [31:0] ICAR = 32'h12345678;
  logic        clk = 1'b0;
  logic        rst_n, trk_en, fcw_load;
  logic [31:0] tx_prn_fcw, tx_car_fcw;
  logic [10:0] chip_init;
  logic [31:0] car_phase, code_phase, prn_fcw_act, car_fcw_act;
  logic [10:0] code_chip;
  logic        chip_strobe, half_chip_strobe, rx_prn_sop;
  logic [15:0] epoch_cnt;
  int checks = 0;
  int errors = 0;
  // reference: total code phase since load in 2^-32 chip units, chip index derived by division
  longint unsigned m_total, m_base;
  logic [31:0] m_car, m_prn, m_caract;
  logic [15:0] m_epoch;
  logic        m_cs, m_hs, m_sop;
  trk_code_car_nco #(.CODE_LEN(CL), .INIT_PRN_FCW(IPRN), .INIT_CAR_FCW(ICAR)) dut (
    .rx_clk(clk), .rx_rst_n(rst_n), .trk_en(trk_en), .tx_prn_fcw(tx_prn_fcw),
    .tx_car_fcw(tx_car_fcw), .fcw_load(fcw_load), .chip_init(chip_init),
    .car_phase(car_phase), .code_phase(code_phase), .code_chip(code_chip),
    .chip_strobe(chip_strobe), .half_chip_strobe(half_chip_strobe), .rx_prn_sop(rx_prn_sop),
    .epoch_cnt(epoch_cnt), .prn_fcw_act(prn_fcw_act), .car_fcw_act(car_fcw_act)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic longint unsigned m_chip();
    return (m_base + (m_total >> 32)) % CL;
  endfunction
  task automatic model_step();
    longint unsigned old;
    if (!rst_n) begin
      m_total = 0; m_base = 0; m_car = 0; m_epoch = 0;
      m_prn = IPRN; m_caract = ICAR; m_cs = 0; m_hs = 0; m_sop = 0;
    end else if (fcw_load) begin
      m_total = 0; m_car = 0; m_epoch = 0;
      m_base = chip_init < CL ? chip_init : 0;
      m_prn = tx_prn_fcw; m_caract = tx_car_fcw; m_cs = 0; m_hs = 0; m_sop = 0;
    end else if (trk_en) begin
      old = m_total;
      m_total += m_prn;
      m_car += m_caract;
      m_cs = (m_total >> 32) != (old >> 32);
      m_hs = !m_cs && (m_total >> 31) != (old >> 31);
      m_sop = m_cs && m_chip() == 0;
      if (m_sop) begin
        m_epoch++;
        m_prn = tx_prn_fcw;
        m_caract = tx_car_fcw;
      end
    end else begin
      m_cs = 0; m_hs = 0; m_sop = 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("car_phase", car_phase, m_car);
    check("code_phase", code_phase, m_total[31:0]);
    check("code_chip", code_chip, m_chip());
    check("chip_strobe", chip_strobe, m_cs);
    check("half_chip_strobe", half_chip_strobe, m_hs);
    check("rx_prn_sop", rx_prn_sop, m_sop);
    check("epoch_cnt", epoch_cnt, m_epoch);
    check("prn_fcw_act", prn_fcw_act, m_prn);
    check("car_fcw_act", car_fcw_act, m_caract);
  endtask
  initial begin
    rst_n = 1'b0; trk_en = 1'b1; fcw_load = 1'b0; chip_init = '0;
    tx_prn_fcw = IPRN; tx_car_fcw = 32'h11111111;
    repeat (3) tick();
    check("rst_car_phase", car_phase, 0);
    check("rst_prn_act", prn_fcw_act, IPRN);
    check("rst_car_act", car_fcw_act, ICAR);
    rst_n = 1'b1; trk_en = 1'b0;
    repeat (3) tick();
    check("hold_code_phase", code_phase, 0);
    trk_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) tx_prn_fcw = 32'h80000000;
      tick();
      if (k <= 16) begin
        check("ep_chip_strobe", chip_strobe, k % 4 == 0);
        check("ep_half_strobe", half_chip_strobe, k % 4 == 2);
        check("ep_sop", rx_prn_sop, k == 16);
        check("ep_prn_act", prn_fcw_act, k == 16 ? 32'h80000000 : IPRN);
      end else check("ep_fast_chip", chip_strobe, k % 2 == 0);
      if (k == 16) begin
        check("ep_chip0", code_chip, 0);
        check("ep_epoch1", epoch_cnt, 1);
      end
    end
    tx_prn_fcw = 32'h40000000; chip_init = 11'd3; fcw_load = 1'b1;
    tick();
    fcw_load = 1'b0;
    check("load_chip", code_chip, 3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("load_sop", rx_prn_sop, k == 4);
    end
    chip_init = 11'd2047; fcw_load = 1'b1;
    tick();
    fcw_load = 1'b0;
    check("load_bad_chip", code_chip, 0);
    tx_car_fcw = 32'h80000000; fcw_load = 1'b1;
    tick();
    fcw_load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("car_wrap", car_phase, k % 2 ? 32'h80000000 : 32'h0);
    end
    tick();
    trk_en = 1'b0;
    repeat (10) begin
      tick();
      check("pause_strobe", chip_strobe | half_chip_strobe | rx_prn_sop, 0);
    end
    trk_en = 1'b1;
    repeat (6) tick();
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(0, 499) != 0;
      trk_en = $urandom_range(0, 7) != 0;
      fcw_load = $urandom_range(0, 63) == 0;
      chip_init = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 15) == 0)
        case ($urandom_range(0, 4))
          0: tx_prn_fcw = 32'h0;
          1: tx_prn_fcw = 32'hFFFFFFFF;
          2: tx_prn_fcw = 32'h80000000;
          default: tx_prn_fcw = $urandom;
        endcase
      if ($urandom_range(0, 15) == 0) tx_car_fcw = $urandom;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
